mod_unit: RTL and testbench
===========================

MOD_UNIT -- requirements
Module: mod_unit

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 O  output  16  signed remainder of last completed operation; registered.
REQ-004 X  input  16  signed dividend, two's complement.
REQ-005 Y  input  16  signed divisor, two's complement.
REQ-006 L  input  1  load/start strobe, sampled on rising clk edge.
REQ-007 busy  output  1  high while a computation is in progress; registered.
REQ-008 Port order SHALL be O, X, Y, clk, L, rst_n, busy (first five positional-compatible with existing benches).

Function
REQ-009 Operation SHALL compute O = X rem Y with truncating division semantics: the remainder's sign follows X, and |O| < |Y|.
REQ-010 Two states SHALL exist: IDLE and CALC.
REQ-011 In IDLE, L=1 at a rising edge SHALL latch X and Y, take the magnitudes into 17-bit unsigned internal registers, record the sign of X, clear the partial remainder, load the iteration counter with 16, and enter CALC with busy=1.
REQ-012 In CALC, each rising edge SHALL perform one restoring shift-subtract step on the magnitudes and decrement the counter.
REQ-013 After the 16th CALC edge, O SHALL be updated with the sign-corrected remainder, busy SHALL drop to 0, and the state SHALL return to IDLE, all on that same edge.
REQ-014 Latency SHALL be fixed: O is valid 16 rising edges after the load edge, independent of operand values.
REQ-015 L=1 while in CALC SHALL abort the current operation and restart with the newly presented X, Y (same behaviour as REQ-011); O keeps its previous value.
REQ-016 L=0 in IDLE SHALL hold O and all state unchanged.
REQ-017 X and Y SHALL be ignored except on load edges; operand changes during CALC SHALL not affect the result.
REQ-018 Y=0 SHALL yield O = X after the normal 16-cycle latency, with no error flag.
REQ-019 X = -32768 SHALL be handled exactly (magnitude 32768 held in 17 bits).
REQ-020 Y = -32768 SHALL yield O = X for every X except -32768, which SHALL yield 0.
REQ-021 O SHALL change only at completion edges (REQ-013) or on reset; it SHALL never show intermediate values.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for clk, force O=0, busy=0, state=IDLE, and clear the counter and internal registers.
REQ-023 Reset asserted mid-CALC SHALL discard the operation; after release the block SHALL wait in IDLE for L.
REQ-024 L sampled high on the first rising edge after rst_n deasserts SHALL be honoured as a normal load.

Verification
REQ-025 Load X=25, Y=5 -> after 16 edges O=0 and busy=0; X=301, Y=39 -> O=28; X=18543, Y=5000 -> O=3543.
REQ-026 Signs: (-301, 39) -> O=-28; (301, -39) -> O=28; (-301, -39) -> O=-28.
REQ-027 Edges: (1234, 0) -> O=1234; (-32768, 7) -> O=-1; (-32768, -32768) -> O=0; (5, 9) -> O=5.
REQ-028 Restart: load (301, 39), then at CALC edge 5 load (1762, 345) -> O stays at its old value until 16 edges after the second load, then O=37.
REQ-029 Reset: load (9956, 2489), assert rst_n=0 between clock edges at edge 8 -> O=0 and busy=0 immediately; after release with L=0, O holds 0 indefinitely.
REQ-030 Hold: after a completed result, keep L=0 for 20 cycles while toggling X and Y -> O and busy remain constant.

Source files
------------

// File: rtl/mod_unit.sv
// Sequential signed remainder unit: 16-cycle restoring shift-subtract on operand magnitudes.
// The result is sign-corrected to follow the dividend and registered on completion.
module mod_unit (
  output logic signed [15:0] O,
  input  logic signed [15:0] X,
  input  logic signed [15:0] Y,
  input  logic               clk,
  input  logic               L,
  input  logic               rst_n,
  output logic               busy
);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e             state_q, state_d;
  logic        [16:0] dvd_q, dvd_d;
  logic        [16:0] dvs_q, dvs_d;
  logic        [16:0] rem_q, rem_d;
  logic               neg_q, neg_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic signed [15:0] o_q, o_d;

  logic [16:0] x_ext, y_ext, mag_x, mag_y;
  logic [16:0] rem_shift, rem_step;
  logic        last_step;
  logic        unused_bits;

  // 17 bits so that -32768 has a representable magnitude.
  assign x_ext = {X[15], X};
  assign y_ext = {Y[15], Y};
  assign mag_x = X[15] ? (~x_ext + 17'd1) : x_ext;
  assign mag_y = Y[15] ? (~y_ext + 17'd1) : y_ext;

  // Partial remainder stays below 2^16 (divisor <= 32768, or zero divisor), so bit 16 never
  // needs to be shifted; dividend magnitude never exceeds 2^15.
  assign rem_shift = {rem_q[15:0], dvd_q[15]};
  assign rem_step  = (rem_shift >= dvs_q) ? (rem_shift - dvs_q) : rem_shift;
  assign last_step = (state_q == StCalc) && (cnt_q == 5'd1);

  assign unused_bits = ^{rem_q[16], dvd_q[16]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (L) begin
      state_d = StCalc;
    end else if (last_step) begin
      state_d = StIdle;
    end
  end

  // A load in either state (re)starts the operation; O is untouched until completion.
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    o_d   = o_q;
    if (L) begin
      dvd_d = mag_x;
      dvs_d = mag_y;
      rem_d = '0;
      neg_d = X[15];
      cnt_d = 5'd16;
    end else if (state_q == StCalc) begin
      dvd_d = {dvd_q[15:0], 1'b0};
      rem_d = rem_step;
      cnt_d = cnt_q - 5'd1;
      if (last_step) begin
        o_d = neg_q ? -rem_step[15:0] : rem_step[15:0];
      end
    end
  end

  assign O    = o_q;
  assign busy = (state_q == StCalc);

endmodule

// File: tb/tb_mod_unit.sv
// Directed bench for mod_unit: expected remainders queued at load, popped at completion.
module tb_mod_unit;

  logic signed [15:0] O, X, Y;
  logic               clk, L, rst_n, busy;

  int tests = 0;
  int fails = 0;
  logic signed [15:0] exp_q[$];

  mod_unit dut (
    .O    (O),
    .X    (X),
    .Y    (Y),
    .clk  (clk),
    .L    (L),
    .rst_n(rst_n),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] ref_rem(input logic signed [15:0] x,
                                                 input logic signed [15:0] y);
    int xi, yi;
    xi = x;
    yi = y;
    if (yi == 0) return x;
    return 16'(xi % yi);
  endfunction

  // Called at a negedge with L already asserted for the coming edge; waits for completion.
  task automatic wait_done(input string tag, input logic signed [15:0] prev);
    int n;
    logic moved;
    logic signed [15:0] exp;
    n = 0;
    moved = 1'b0;
    @(negedge clk);
    L = 1'b0;
    check({tag, "_busy_hi"}, 32'(busy), 1);
    while (busy && n < 40) begin
      X = 16'($urandom);
      Y = 16'($urandom);
      if (O !== prev) moved = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 16);
    check({tag, "_no_interim"}, 32'(moved), 0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_O"}, O, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic signed [15:0] x,
                        input logic signed [15:0] y, input logic signed [15:0] exp);
    logic signed [15:0] prev;
    prev = O;
    X = x;
    Y = y;
    L = 1'b1;
    exp_q.push_back(exp);
    wait_done(tag, prev);
  endtask

  initial begin
    logic signed [15:0] prev, rx, ry;
    logic moved;
    rst_n = 1'b0;
    L = 1'b0;
    X = 16'sd0;
    Y = 16'sd0;
    #12;
    check("reset_O", O, 0);
    check("reset_busy", 32'(busy), 0);

    // Load honoured on the very first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    run_op("v25_5", 16'sd25, 16'sd5, 16'sd0);
    run_op("v301_39", 16'sd301, 16'sd39, 16'sd28);
    run_op("v18543_5000", 16'sd18543, 16'sd5000, 16'sd3543);
    run_op("neg_x", -16'sd301, 16'sd39, -16'sd28);
    run_op("neg_y", 16'sd301, -16'sd39, 16'sd28);
    run_op("neg_xy", -16'sd301, -16'sd39, -16'sd28);
    run_op("y_zero", 16'sd1234, 16'sd0, 16'sd1234);
    run_op("xmin_7", -16'sd32768, 16'sd7, -16'sd1);
    run_op("xmin_ymin", -16'sd32768, -16'sd32768, 16'sd0);
    run_op("small_x", 16'sd5, 16'sd9, 16'sd5);
    run_op("ymin_x", 16'sd12345, -16'sd32768, 16'sd12345);
    run_op("xmin_y0", -16'sd32768, 16'sd0, -16'sd32768);

    for (int i = 0; i < 6; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      run_op($sformatf("rand%0d", i), rx, ry, ref_rem(rx, ry));
    end

    // Restart on the 5th CALC edge: only the second load produces a result.
    prev = O;
    X = 16'sd301;
    Y = 16'sd39;
    L = 1'b1;
    @(negedge clk);
    L = 1'b0;
    repeat (4) @(negedge clk);
    X = 16'sd1762;
    Y = 16'sd345;
    L = 1'b1;
    exp_q.push_back(16'sd37);
    wait_done("restart", prev);

    // Asynchronous reset mid-operation.
    X = 16'sd9956;
    Y = 16'sd2489;
    L = 1'b1;
    @(negedge clk);
    L = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_O", O, 0);
    check("rst_mid_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    moved = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (O !== 16'sd0 || busy !== 1'b0) moved = 1'b1;
    end
    check("rst_hold", 32'(moved), 0);

    // Hold in IDLE with operands toggling.
    run_op("pre_hold", 16'sd1000, 16'sd7, 16'sd6);
    prev = O;
    moved = 1'b0;
    repeat (20) begin
      X = 16'($urandom);
      Y = 16'($urandom);
      @(negedge clk);
      if (O !== prev || busy !== 1'b0) moved = 1'b1;
    end
    check("idle_hold", 32'(moved), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
